// File: rtl/cfg_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_types_pkg
// Description : Shared state encoding and constants for the accelerator
//               bus-master sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_types_pkg;

  // Sequencer states, kept as plain 4-bit codes for legacy tool flows
  typedef logic [3:0] bus_mst_state_t;

  localparam bus_mst_state_t S_IDLE     = 4'd0;
  localparam bus_mst_state_t S_LOAD     = 4'd1;
  localparam bus_mst_state_t S_CTRL     = 4'd2;
  localparam bus_mst_state_t S_WAIT     = 4'd3;
  localparam bus_mst_state_t S_STAT_REQ = 4'd4;
  localparam bus_mst_state_t S_STAT_CAP = 4'd5;
  localparam bus_mst_state_t S_RD_REQ   = 4'd6;
  localparam bus_mst_state_t S_RD_CAP   = 4'd7;
  localparam bus_mst_state_t S_RD_OUT   = 4'd8;
  localparam bus_mst_state_t S_FINISH   = 4'd9;

  // Status word 0 follows the control words in the config region
  localparam int             STAT_WORD_IDX    = 2;
  localparam logic [7:0]     JOB_TIMEOUT_CODE = 8'hFF;
  localparam int             START_BIT        = 0;

endpackage
`default_nettype wire

// File: rtl/accel_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : accel_bus_master
// Description : Single-job sequencer driving the accelerator's internal
//               memory bus: load inputs, start, wait for done, read status,
//               stream results out with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_bus_master
  import cfg_types_pkg::*;
#(
  parameter int INT_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WORDS     = STAT_WORD_IDX,
  parameter int CNT_WIDTH      = 10,
  parameter int RES_OFFSET     = 0,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DATA_WIDTH-1:0]         cmd_ctrl,
  input  logic [CNT_WIDTH-1:0]          cmd_in_words,
  input  logic [CNT_WIDTH-1:0]          cmd_out_words,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          mem_req,
  output logic [INT_ADDR_WIDTH-1:0]     mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH/8-1:0]       mem_be,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          acc_done,
  output logic                          busy,
  output logic                          job_done,
  output logic [7:0]                    job_status
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BE_W);
  localparam int IDX_W = INT_ADDR_WIDTH - 1 - ALIGN;

  localparam logic [INT_ADDR_WIDTH-1:0] C_DATA_BASE = {1'b1, {(INT_ADDR_WIDTH-1){1'b0}}};
  localparam logic [INT_ADDR_WIDTH-1:0] C_STAT_ADDR = INT_ADDR_WIDTH'(CTRL_WORDS) << ALIGN;
  localparam logic [TO_WIDTH-1:0]       C_TIMEOUT   = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0]     C_START     = DATA_WIDTH'(1) << START_BIT;
  localparam logic [IDX_W-1:0]          C_RES_OFS   = IDX_W'(RES_OFFSET);

  bus_mst_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0]    in_words_q, in_words_d;
  logic [CNT_WIDTH-1:0]    out_words_q, out_words_d;
  logic [CNT_WIDTH-1:0]    in_idx_q, in_idx_d;
  logic [CNT_WIDTH-1:0]    out_idx_q, out_idx_d;
  logic [TO_WIDTH-1:0]     to_q, to_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              job_status_q, job_status_d;

  logic                      w_req;
  logic                      w_we;
  logic [INT_ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [IDX_W-1:0]          w_wr_idx;
  logic [IDX_W-1:0]          w_rd_idx;

  // Data-region word indices; wrap silently at the region size
  assign w_wr_idx = IDX_W'(in_idx_q);
  assign w_rd_idx = C_RES_OFS + IDX_W'(out_idx_q);

  // Next-state, counter and bus-access decode
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    in_words_d   = in_words_q;
    out_words_d  = out_words_q;
    in_idx_d     = in_idx_q;
    out_idx_d    = out_idx_q;
    to_d         = to_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    job_status_d = job_status_q;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ctrl_d      = cmd_ctrl;
          in_words_d  = cmd_in_words;
          out_words_d = cmd_out_words;
          in_idx_d    = '0;
          out_idx_d   = '0;
          to_d        = '0;
          state_d     = (cmd_in_words != '0) ? S_LOAD : S_CTRL;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_req    = 1'b1;
          w_we     = 1'b1;
          w_addr   = C_DATA_BASE | (INT_ADDR_WIDTH'(w_wr_idx) << ALIGN);
          w_wdata  = in_data;
          in_idx_d = in_idx_q + CNT_WIDTH'(1);
          if (in_idx_q == in_words_q - CNT_WIDTH'(1)) state_d = S_CTRL;
        end
      end
      S_CTRL: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_wdata = ctrl_q | C_START;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        to_d = to_q + TO_WIDTH'(1);
        // done wins over a timeout landing in the same cycle
        if (acc_done) begin
          state_d = S_STAT_REQ;
        end else if (to_d == C_TIMEOUT) begin
          job_status_d = JOB_TIMEOUT_CODE;
          state_d      = S_FINISH;
        end
      end
      S_STAT_REQ: begin
        w_req   = 1'b1;
        w_addr  = C_STAT_ADDR;
        state_d = S_STAT_CAP;
      end
      S_STAT_CAP: begin
        job_status_d = mem_rdata[7:0];
        state_d      = (out_words_q != '0) ? S_RD_REQ : S_FINISH;
      end
      S_RD_REQ: begin
        w_req   = 1'b1;
        w_addr  = C_DATA_BASE | (INT_ADDR_WIDTH'(w_rd_idx) << ALIGN);
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        state_d     = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_idx_d   = out_idx_q + CNT_WIDTH'(1);
          state_d     = (out_idx_q == out_words_q - CNT_WIDTH'(1)) ? S_FINISH : S_RD_REQ;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctrl_q       <= '0;
      in_words_q   <= '0;
      out_words_q  <= '0;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      to_q         <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      job_status_q <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      in_words_q   <= in_words_d;
      out_words_q  <= out_words_d;
      in_idx_q     <= in_idx_d;
      out_idx_q    <= out_idx_d;
      to_q         <= to_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      job_status_q <= job_status_d;
    end
  end

  // Reset masks the bus immediately so an aborted job issues no further access
  assign mem_req    = w_req & ~rst;
  assign mem_we     = w_we & ~rst;
  assign mem_addr   = w_addr;
  assign mem_wdata  = w_wdata;
  assign mem_be     = {BE_W{mem_req}};
  assign in_ready   = (state_q == S_LOAD) & ~rst;
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign job_done   = (state_q == S_FINISH) & ~rst;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign job_status = job_status_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_bus_master
// Description : Directed scoreboard bench for accel_bus_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_bus_master;

  localparam int AW      = 20;
  localparam int DW      = 32;
  localparam int CW      = 10;
  localparam int RES_OFS = 4;
  localparam int TO_CYC  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_ctrl = '0;
  logic [CW-1:0] cmd_in_words = '0;
  logic [CW-1:0] cmd_out_words = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          acc_done = 1'b0;
  logic          busy;
  logic          job_done;
  logic [7:0]    job_status;

  always #5 clk = ~clk;

  accel_bus_master #(
    .INT_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_WORDS(2), .CNT_WIDTH(CW),
    .RES_OFFSET(RES_OFS), .TIMEOUT_CYCLES(TO_CYC), .TO_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
    .cmd_in_words(cmd_in_words), .cmd_out_words(cmd_out_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .acc_done(acc_done), .busy(busy), .job_done(job_done), .job_status(job_status)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } bus_t;

  bus_t          exp_bus[$];
  logic [DW-1:0] exp_out[$];
  int            checks = 0;
  int            errors = 0;
  int            done_count = 0;
  int            hs_count = 0;
  logic [DW-1:0] status_val = '0;

  // Memory model: status word at byte 0x8, everything else a function of address
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 20'h00008) return status_val;
    return 32'hD000_0000 ^ DW'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_req && !mem_we) mem_rdata <= rd_model(mem_addr);
    else                    mem_rdata <= 32'hDEAD_BEEF;
  end

  // Bus scoreboard
  bus_t mon_e;
  always @(negedge clk) begin
    if (mem_req) begin
      checks++;
      assert (exp_bus.size() != 0) else begin
        errors++;
        $error("FAIL bus_unexpected: observed req addr=%h we=%0b, expected no access", mem_addr, mem_we);
      end
      if (exp_bus.size() != 0) begin
        mon_e = exp_bus.pop_front();
        checks++;
        assert (mem_addr === mon_e.addr && mem_we === mon_e.we && mem_be === 4'hF &&
                (!mon_e.we || mem_wdata === mon_e.wdata)) else begin
          errors++;
          $error("FAIL bus_access: observed addr=%h we=%0b be=%h wdata=%h, expected addr=%h we=%0b be=f wdata=%h",
                 mem_addr, mem_we, mem_be, mem_wdata, mon_e.addr, mon_e.we, mon_e.wdata);
        end
      end
    end
  end

  // Output stream scoreboard and stall-stability monitor
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] out_e;
  always @(negedge clk) begin
    if (!rst && prev_valid && !prev_hs) begin
      checks++;
      assert (out_valid === 1'b1 && out_data === prev_data) else begin
        errors++;
        $error("FAIL out_stable: observed valid=%0b data=%h, expected valid=1 data=%h", out_valid, out_data, prev_data);
      end
    end
    if (!rst && out_valid && out_ready) begin
      hs_count++;
      checks++;
      assert (exp_out.size() != 0) else begin
        errors++;
        $error("FAIL out_unexpected: observed data=%h, expected no output", out_data);
      end
      if (exp_out.size() != 0) begin
        out_e = exp_out.pop_front();
        checks++;
        assert (out_data === out_e) else begin
          errors++;
          $error("FAIL out_data: observed %h expected %h", out_data, out_e);
        end
      end
    end
    prev_valid = out_valid && !rst;
    prev_hs    = out_valid && out_ready;
    prev_data  = out_data;
    if (job_done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_t e;
    e.addr = a; e.we = 1'b1; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    bus_t e;
    e.addr = a; e.we = 1'b0; e.wdata = '0;
    exp_bus.push_back(e);
  endtask

  task automatic send_cmd(input logic [DW-1:0] ctrl, input int inw, input int outw);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_ctrl = ctrl;
    cmd_in_words = CW'(inw); cmd_out_words = CW'(outw);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d;
    push_wr(20'h80000 | AW'(idx * 4), d);
    @(negedge clk);
    chk("in_ready_load", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic acc_pulse(input int delay, input logic [DW-1:0] st, input int outw);
    logic [AW-1:0] a;
    repeat (delay) tick();
    status_val = st;
    push_rd(20'h00008);
    for (int k = 0; k < outw; k++) begin
      a = 20'h80000 | AW'((RES_OFS + k) * 4);
      push_rd(a);
      exp_out.push_back(32'hD000_0000 ^ DW'(a));
    end
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int waited);
    waited = 0;
    while (waited < bound) begin
      @(negedge clk);
      waited++;
      if (job_done) break;
    end
    checks++;
    assert (job_done === 1'b1) else begin
      errors++;
      $error("FAIL job_done_wait: observed no job_done within %0d cycles, expected pulse", bound);
    end
    tick();
  endtask

  task automatic end_job(input logic [7:0] st, input int exp_done);
    repeat (3) tick();
    chk("job_done_once", done_count, exp_done);
    chk("job_status", {24'b0, job_status}, {24'b0, st});
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("bus_queue_empty", exp_bus.size(), 32'd0);
    chk("out_queue_empty", exp_out.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_job_done", {31'b0, job_done}, 32'd0);
    chk("rst_job_status", {24'b0, job_status}, 32'd0);
    tick();

    // Job 1: three back-to-back words, done after 10 cycles, status 0x12
    send_cmd(32'h0000_2000, 3, 0);
    send_word(0, 32'hAAAA_0001);
    send_word(1, 32'hBBBB_0002);
    send_word(2, 32'hCCCC_0003);
    push_wr(20'h00000, 32'h0000_2001);
    tick();
    chk("busy_wait", {31'b0, busy}, 32'd1);
    acc_pulse(10, 32'h0000_0012, 0);
    wait_done(20, w);
    end_job(8'h12, 1);

    // Job 2: gap in the input stream, two results with a 5-cycle stall
    hs_count  = 0;
    out_ready = 1'b0;
    send_cmd(32'h0000_0040, 2, 2);
    send_word(0, 32'h1111_0000);
    tick();
    tick();
    send_word(1, 32'h2222_0000);
    push_wr(20'h00000, 32'h0000_0041);
    tick();
    acc_pulse(3, 32'hFFFF_FF5A, 2);
    w = 0;
    while (w < 50 && out_valid !== 1'b1) begin
      @(negedge clk);
      w++;
    end
    chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
    repeat (5) tick();
    out_ready = 1'b1;
    wait_done(30, w);
    chk("handshakes", hs_count, 32'd2);
    end_job(8'h5A, 2);

    // Job 3: accelerator never finishes -> timeout code, no readback
    send_cmd(32'h0000_0100, 0, 1);
    push_wr(20'h00000, 32'h0000_0101);
    wait_done(40, w);
    chk("timeout_latency", w, 32'd22);
    end_job(8'hFF, 3);

    // Job 4: reset in the middle of the load phase
    send_cmd(32'h0000_2000, 3, 0);
    send_word(0, 32'h4444_0000);
    send_word(1, 32'h4444_0001);
    in_valid = 1'b1;
    in_data  = 32'h4444_0002;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_no_done", done_count, 32'd3);
    chk("abort_bus_queue", exp_bus.size(), 32'd0);
    tick();

    // Job 5: clean job after the abort starts again at index 0
    send_cmd(32'h0000_2000, 1, 1);
    send_word(0, 32'h5555_0000);
    push_wr(20'h00000, 32'h0000_2001);
    tick();
    acc_pulse(0, 32'h0000_0033, 1);
    wait_done(20, w);
    end_job(8'h33, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accel_bus_master.md
Name: accel_bus_master

Overview:
- Initiator-side sequencer that drives the accelerator wrapper's internal memory bus (req/addr/we/be/wdata/rdata) for one job.
- Per accepted command it:
  - streams input words into the accelerator data region;
  - writes control word 0 with the start bit set;
  - waits for done, then reads status word 0;
  - reads result words back and streams them out with backpressure.
- Sits between a host-side stream/command source (test harness or DMA front-end) and the accelerator top, replacing the AXI-to-memory path in bus-master-only configurations.

Parameters:
- INT_ADDR_WIDTH, 20, byte address width of internal bus; MSB=1 selects data region, MSB=0 selects config region.
- DATA_WIDTH, 32, bus word width; byte enables are DATA_WIDTH/8 wide.
- CTRL_WORDS, 2, number of control words; status word 0 sits at config word index CTRL_WORDS.
- CNT_WIDTH, 10, width of input/output word counts.
- RES_OFFSET, 0, data-region word index of the first result word.
- TIMEOUT_CYCLES, 65535, maximum cycles waited for done; must be < 2**TO_WIDTH.
- TO_WIDTH, 16, timeout counter width.

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- cmd_valid in 1: command valid.
- cmd_ready out 1: high only in IDLE.
- cmd_ctrl in DATA_WIDTH: control word 0 image; bit 0 is forced to 1 when written.
- cmd_in_words in CNT_WIDTH: words to load (0 allowed).
- cmd_out_words in CNT_WIDTH: words to read back (0 allowed).
- in_valid/in_ready in/out 1: input stream handshake.
- in_data in DATA_WIDTH: input word.
- out_valid/out_ready out/in 1: result stream handshake.
- out_data out DATA_WIDTH: result word.
- mem_req out 1: bus request, one access per cycle.
- mem_addr out INT_ADDR_WIDTH: byte address, word aligned (low $clog2(DATA_WIDTH/8) bits = 0).
- mem_we out 1: write enable.
- mem_be out DATA_WIDTH/8: byte enables, all ones on every access.
- mem_wdata out DATA_WIDTH: write data.
- mem_rdata in DATA_WIDTH: read data, valid exactly one cycle after a read request.
- acc_done in 1: accelerator done (level or pulse).
- busy out 1: high in every state except IDLE.
- job_done out 1: one-cycle pulse on job completion.
- job_status out 8: captured status word 0 [7:0], or 8'hFF on timeout.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. Internal counters 0, state IDLE. Reset mid-job aborts immediately with no further bus accesses and no job_done. It does not clear the accelerator's start bit.
- IDLE:
  - cmd_valid&cmd_ready latches ctrl and both counts, clears in-counter, out-counter and timeout counter.
  - Goes to LOAD if in_words>0, else CTRL.
- LOAD:
  - in_ready=1. Each in_valid cycle issues mem_req=1, we=1, addr={1'b1, idx<<ALIGN}, wdata=in_data.
  - No bus access when in_valid=0.
  - After the word with idx=in_words-1 -> CTRL.
  - Write throughput is one word per cycle.
- CTRL: single write, addr=0, wdata=ctrl|1 -> WAIT.
- WAIT:
  - mem_req=0; timeout counter increments each cycle.
  - acc_done=1 -> STAT_REQ; acc_done is checked before timeout when both occur in the same cycle.
  - Counter reaching TIMEOUT_CYCLES -> job_status=8'hFF, skip readback -> FINISH.
- STAT_REQ: read, addr=CTRL_WORDS<<ALIGN -> STAT_CAP.
- STAT_CAP: job_status<=mem_rdata[7:0]. Goes to RD_REQ if out_words>0, else FINISH.
- RD_REQ: read, addr={1'b1, (RES_OFFSET+idx)<<ALIGN} -> RD_CAP.
- RD_CAP: out_data<=mem_rdata, out_valid<=1 -> RD_OUT.
- RD_OUT:
  - Hold out_data/out_valid stable until out_ready.
  - On handshake, idx++; if idx==out_words-1 was sent -> FINISH, else RD_REQ.
  - Readback throughput is at most one word per 3 cycles.
- FINISH: job_done=1 for one cycle -> IDLE.
- Width rules:
  - Data-region index arithmetic is truncated to INT_ADDR_WIDTH-1-ALIGN bits; wrap is silent.
  - Count compares are CNT_WIDTH wide; count=2**CNT_WIDTH-1 is the maximum.
- Never asserts mem_req in IDLE, WAIT, STAT_CAP, RD_CAP, RD_OUT or FINISH.

Decomposition:
- Shared package cfg_types_pkg gets:
  - typedef bus_mst_state_t (the 10 states above);
  - constants STAT_WORD_IDX=CTRL_WORDS, JOB_TIMEOUT_CODE=8'hFF, START_BIT=0.
- No sub-module; one FSM plus three counters (in idx, out idx, timeout).

Test Plan:
- Job with ctrl=32'h0000_2000, in_words=3 (data A,B,C back-to-back) -> writes to 0x80000/0x80004/0x80008, then write 0x2001 to addr 0.
- Input stream with a 2-cycle in_valid gap after word 0 -> no mem_req during the gap; addresses stay contiguous.
- acc_done after 10 cycles with status mem_rdata=32'h12 -> read at addr 0x8, job_status=8'h12, job_done pulse exactly once.
- out_words=2, RES_OFFSET=4, out_ready low for 5 cycles on word 0 -> reads 0x80010 then 0x80014; out_data stable while stalled; 2 handshakes total.
- TIMEOUT_CYCLES=20, acc_done never asserted -> job_status=8'hFF after 20 WAIT cycles, no readback, job_done pulses.
- rst asserted during LOAD after word 1 -> next cycle mem_req=0, busy=0, cmd_ready=1; a following job runs cleanly from index 0.
